// File: rtl/serial_pkg.sv
// Shared definitions for the 11-bit serial link (transmit and receive sides).
package serial_pkg;

  localparam int   FRAME_BITS  = 11;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam int   BITCNT_W    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Parity bit that makes the 9-bit {parity, data} group even (odd = 0) or odd (odd = 1).
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Byte handshake into the transmitter plus its line and status outputs.
interface serial_tx_if;
  logic [7:0] data_in;
  logic       valid;
  logic       ready;
  logic       txd;
  logic       busy;
  logic       done;

  modport master (
    output data_in, valid,
    input  ready, txd, busy, done
  );

  modport slave (
    input  data_in, valid,
    output ready, txd, busy, done
  );
endinterface

// File: rtl/serial_tx_baud_gen.sv
// Bit-period divider: counts 0..DIV-1 while running, flags the last cycle of each bit.
module tx_baud_gen #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_tick
);
  import serial_pkg::*;

  localparam int            CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_tick = run && (cnt_q == LAST);

  // Next count: held at zero when idle, wraps at the end of each bit period.
  always_comb begin
    cnt_d = cnt_q;
    if (!run || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Divider register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Serial frame transmitter: start, 8 data bits LSB-first, parity, stop; line idles high.
module serial_tx #(
  parameter int DIV        = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  serial_tx_if.slave  bus
);
  import serial_pkg::*;

  localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(FRAME_BITS - 1);

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic [BITCNT_W-1:0]     bitcnt_q, bitcnt_d;
  logic                    txd_q, txd_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    run;
  logic                    bit_tick;

  assign run = (state_q == SEND);

  tx_baud_gen #(.DIV(DIV)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .bit_tick (bit_tick)
  );

  // Next-state logic: accept a byte in IDLE, step through the frame on each bit tick.
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    bitcnt_d = bitcnt_q;
    txd_d    = txd_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d = IDLE_LEVEL;
        if (bus.valid && ready_q) begin
          frame_d  = {STOP_LEVEL, calc_parity(bus.data_in, PARITY_ODD), bus.data_in, START_LEVEL};
          bitcnt_d = '0;
          txd_d    = START_LEVEL;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (bit_tick) begin
          if (bitcnt_q == LAST_BIT) begin
            bitcnt_d = '0;
            txd_d    = IDLE_LEVEL;
            ready_d  = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            bitcnt_d = bitcnt_q + BITCNT_W'(1);
            txd_d    = frame_q[bitcnt_d];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, frame and registered outputs; reset drops any frame in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      frame_q  <= '1;
      bitcnt_q <= '0;
      txd_q    <= IDLE_LEVEL;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      bitcnt_q <= bitcnt_d;
      txd_q    <= txd_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.txd   = txd_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
